ex_mem_reg: RTL and testbench

EX/MEM pipeline register for the 5-stage MIPS core. Captures the EX stage result each cycle: destination register, write enable, write data, HI/LO write-back. Also holds the 2-cycle multiply-accumulate scratch state (`hilo_temp`, `cnt`) that EX reads back while it is stalled. Honours the core's 6-bit stall vector (bubble or hold) and the pipeline flush.

---
 rtl/ex_mem_reg.sv | 122 ++++++++++++
 tb/tb_ex_mem_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: latches the EX result for MEM and keeps the
// multi-cycle multiply-accumulate scratch state that EX reads back while stalled.
module ex_mem_reg #(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic                    flush,
    input  logic [4:0]              ex_wd,
    input  logic                    ex_wreg,
    input  logic [31:0]             ex_wdata,
    input  logic [31:0]             ex_hi,
    input  logic [31:0]             ex_lo,
    input  logic                    ex_whilo,
    input  logic [63:0]             hilo_temp_i,
    input  logic [1:0]              cnt_i,
    output logic [4:0]              mem_wd,
    output logic                    mem_wreg,
    output logic [31:0]             mem_wdata,
    output logic [31:0]             mem_hi,
    output logic [31:0]             mem_lo,
    output logic                    mem_whilo,
    output logic                    mem_valid,
    output logic [63:0]             hilo_temp_o,
    output logic [1:0]              cnt_o,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = BUBBLE_CNT_W'(1);

    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [4:0]              wd_p0;
    logic                    wreg_p0;
    logic [31:0]             wdata_p0;
    logic [31:0]             hi_p0;
    logic [31:0]             lo_p0;
    logic                    whilo_p0;
    logic                    vld_p0;
    logic [63:0]             hilo_temp_p0;
    logic [1:0]              cnt_p0;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_p0;

    logic ex_stalled;
    logic mem_stalled;

    assign ex_stalled  = stall[3];
    assign mem_stalled = stall[4];

    // EX -> MEM boundary; a MEM stall holds everything, regardless of stall[3]
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_p0         <= '0;
            wreg_p0       <= 1'b0;
            wdata_p0      <= '0;
            hi_p0         <= '0;
            lo_p0         <= '0;
            whilo_p0      <= 1'b0;
            vld_p0        <= 1'b0;
            hilo_temp_p0  <= '0;
            cnt_p0        <= '0;
            bubble_cnt_p0 <= '0;
        end else if (flush) begin
            wd_p0        <= '0;
            wreg_p0      <= 1'b0;
            wdata_p0     <= '0;
            hi_p0        <= '0;
            lo_p0        <= '0;
            whilo_p0     <= 1'b0;
            vld_p0       <= 1'b0;
            hilo_temp_p0 <= '0;
            cnt_p0       <= '0;
        end else if (mem_stalled) begin
            wd_p0         <= wd_p0;
            wreg_p0       <= wreg_p0;
            wdata_p0      <= wdata_p0;
            hi_p0         <= hi_p0;
            lo_p0         <= lo_p0;
            whilo_p0      <= whilo_p0;
            vld_p0        <= vld_p0;
            hilo_temp_p0  <= hilo_temp_p0;
            cnt_p0        <= cnt_p0;
            bubble_cnt_p0 <= bubble_cnt_p0;
        end else if (ex_stalled) begin
            wd_p0         <= '0;
            wreg_p0       <= 1'b0;
            wdata_p0      <= '0;
            hi_p0         <= '0;
            lo_p0         <= '0;
            whilo_p0      <= 1'b0;
            vld_p0        <= 1'b0;
            hilo_temp_p0  <= hilo_temp_i;
            cnt_p0        <= cnt_i;
            bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
        end else begin
            wd_p0        <= ex_wd;
            wreg_p0      <= ex_wreg;
            wdata_p0     <= ex_wdata;
            hi_p0        <= ex_hi;
            lo_p0        <= ex_lo;
            whilo_p0     <= ex_whilo;
            vld_p0       <= 1'b1;
            hilo_temp_p0 <= '0;
            cnt_p0       <= '0;
        end
    end

    assign mem_wd      = wd_p0;
    assign mem_wreg    = wreg_p0;
    assign mem_wdata   = wdata_p0;
    assign mem_hi      = hi_p0;
    assign mem_lo      = lo_p0;
    assign mem_whilo   = whilo_p0;
    assign mem_valid   = vld_p0;
    assign hilo_temp_o = hilo_temp_p0;
    assign cnt_o       = cnt_p0;
    assign bubble_cnt  = bubble_cnt_p0;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, advance, bubble, hold, flush priority
// and bubble counter saturation on a narrow-counter instance.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;

    logic [4:0]  mem_wd,    s_mem_wd;
    logic        mem_wreg,  s_mem_wreg;
    logic [31:0] mem_wdata, s_mem_wdata;
    logic [31:0] mem_hi,    s_mem_hi;
    logic [31:0] mem_lo,    s_mem_lo;
    logic        mem_whilo, s_mem_whilo;
    logic        mem_valid, s_mem_valid;
    logic [63:0] hilo_temp_o, s_hilo_temp_o;
    logic [1:0]  cnt_o, s_cnt_o;
    logic [15:0] bubble_cnt;
    logic [3:0]  s_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .mem_valid(mem_valid), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o),
        .bubble_cnt(bubble_cnt)
    );

    ex_mem_reg #(.BUBBLE_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_wd(s_mem_wd), .mem_wreg(s_mem_wreg), .mem_wdata(s_mem_wdata),
        .mem_hi(s_mem_hi), .mem_lo(s_mem_lo), .mem_whilo(s_mem_whilo),
        .mem_valid(s_mem_valid), .hilo_temp_o(s_hilo_temp_o), .cnt_o(s_cnt_o),
        .bubble_cnt(s_bubble_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem_zero(input string tag);
        check({tag, " wd"},    64'(mem_wd),    64'h0);
        check({tag, " wreg"},  64'(mem_wreg),  64'h0);
        check({tag, " wdata"}, 64'(mem_wdata), 64'h0);
        check({tag, " hi"},    64'(mem_hi),    64'h0);
        check({tag, " lo"},    64'(mem_lo),    64'h0);
        check({tag, " whilo"}, 64'(mem_whilo), 64'h0);
        check({tag, " valid"}, 64'(mem_valid), 64'h0);
    endtask

    initial begin
        // Reset with every input nonzero
        rst = 1'b1; flush = 1'b0; stall = 6'b000000;
        ex_wd = 5'h1F; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
        ex_hi = 32'h1234_5678; ex_lo = 32'h8765_4321; ex_whilo = 1'b1;
        hilo_temp_i = 64'hFFFF_0000_FFFF_0000; cnt_i = 2'b11;
        step();
        check_mem_zero("reset");
        check("reset hilo_temp", hilo_temp_o, 64'h0);
        check("reset cnt", 64'(cnt_o), 64'h0);
        check("reset bubble_cnt", 64'(bubble_cnt), 64'h0);
        check("reset sat bubble_cnt", 64'(s_bubble_cnt), 64'h0);

        // Advance
        rst = 1'b0;
        ex_wd = 5'h03; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
        ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
        hilo_temp_i = 64'h0; cnt_i = 2'b00;
        step();
        check("adv wd",    64'(mem_wd),    64'h03);
        check("adv wreg",  64'(mem_wreg),  64'h1);
        check("adv wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("adv hi",    64'(mem_hi),    64'h1);
        check("adv lo",    64'(mem_lo),    64'h2);
        check("adv whilo", 64'(mem_whilo), 64'h1);
        check("adv valid", 64'(mem_valid), 64'h1);
        check("adv cnt",   64'(cnt_o),     64'h0);

        // Accumulate bubble
        stall = 6'b001111; hilo_temp_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
        step();
        check_mem_zero("bubble");
        check("bubble hilo_temp", hilo_temp_o, 64'h0000_0001_0000_0002);
        check("bubble cnt", 64'(cnt_o), 64'h1);
        check("bubble bubble_cnt", 64'(bubble_cnt), 64'h1);

        // Completion after the bubble
        stall = 6'b000000; ex_wd = 5'h07; ex_wdata = 32'h1234_ABCD;
        hilo_temp_i = 64'h0000_0003_0000_0004; cnt_i = 2'b10;
        step();
        check("done cnt", 64'(cnt_o), 64'h0);
        check("done hilo_temp", hilo_temp_o, 64'h0);
        check("done wd", 64'(mem_wd), 64'h07);
        check("done wdata", 64'(mem_wdata), 64'h1234_ABCD);
        check("done valid", 64'(mem_valid), 64'h1);
        check("done bubble_cnt", 64'(bubble_cnt), 64'h1);

        // Data passes through even when the write enable is off
        ex_wreg = 1'b0; ex_wdata = 32'hCAFE_F00D;
        step();
        check("nowreg wreg", 64'(mem_wreg), 64'h0);
        check("nowreg wdata", 64'(mem_wdata), 64'hCAFE_F00D);

        // Hold for 3 cycles while EX changes, then the odd stall[4]-only pattern
        ex_wreg = 1'b1; ex_wdata = 32'hA5A5_A5A5;
        step();
        check("hold load", 64'(mem_wdata), 64'hA5A5_A5A5);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h1111_0000 + 32'(i);
            ex_wd = 5'(i + 9);
            cnt_i = 2'b11;
            step();
            check("hold wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
            check("hold valid", 64'(mem_valid), 64'h1);
            check("hold cnt", 64'(cnt_o), 64'h0);
            check("hold bubble_cnt", 64'(bubble_cnt), 64'h1);
        end
        stall = 6'b010000;
        step();
        check("hold4only wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
        check("hold4only bubble_cnt", 64'(bubble_cnt), 64'h1);

        // Hold keeps scratch state captured by a bubble
        stall = 6'b001111; hilo_temp_i = 64'h55AA_55AA_0F0F_0F0F; cnt_i = 2'b10;
        step();
        check("bubble2 bubble_cnt", 64'(bubble_cnt), 64'h2);
        stall = 6'b011111; hilo_temp_i = 64'h0; cnt_i = 2'b00;
        step();
        check("holdscr hilo_temp", hilo_temp_o, 64'h55AA_55AA_0F0F_0F0F);
        check("holdscr cnt", 64'(cnt_o), 64'h2);

        // Flush beats a bubble request
        stall = 6'b001111; flush = 1'b1; hilo_temp_i = 64'h9999; cnt_i = 2'b01;
        step();
        check_mem_zero("flush");
        check("flush hilo_temp", hilo_temp_o, 64'h0);
        check("flush cnt", 64'(cnt_o), 64'h0);
        check("flush bubble_cnt", 64'(bubble_cnt), 64'h2);

        // Flush beats a hold of a valid instruction
        flush = 1'b0; stall = 6'b000000; ex_wdata = 32'h7777_7777;
        step();
        check("preflush valid", 64'(mem_valid), 64'h1);
        stall = 6'b011111; flush = 1'b1;
        step();
        check("flushhold valid", 64'(mem_valid), 64'h0);
        check("flushhold wdata", 64'(mem_wdata), 64'h0);

        // Reset beats flush and clears a mid-accumulate count
        flush = 1'b0; stall = 6'b001111; cnt_i = 2'b01;
        step();
        check("preRst cnt", 64'(cnt_o), 64'h1);
        rst = 1'b1; flush = 1'b1;
        step();
        check("rstflush cnt", 64'(cnt_o), 64'h0);
        check("rstflush bubble_cnt", 64'(bubble_cnt), 64'h0);

        // Saturation on the 4-bit counter
        rst = 1'b0; flush = 1'b0; stall = 6'b001111;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat 14", 64'(s_bubble_cnt), 64'hE);
            if (i == 15) check("sat 15", 64'(s_bubble_cnt), 64'hF);
            if (i == 16) check("sat 16", 64'(s_bubble_cnt), 64'hF);
        end
        check("sat 20", 64'(s_bubble_cnt), 64'hF);
        check("wide 20", 64'(bubble_cnt), 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
